// File: rtl/score_controller.sv
// Breakout scoring: round-robin award arbitration, saturating score,
// high-score commit at game over.
module score_controller #(
   parameter int unsigned N_SRC     = 4,
   parameter int unsigned PTS_W     = 8,
   parameter int unsigned SCORE_W   = 14,
   parameter int unsigned SCORE_MAX = 9999
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     game_start,
   input  logic                     game_over,
   input  logic [N_SRC-1:0]         evt_req,
   input  logic [N_SRC*PTS_W-1:0]   evt_pts,
   output logic [N_SRC-1:0]         evt_ack,
   output logic [SCORE_W-1:0]       score,
   output logic [SCORE_W-1:0]       high_score,
   output logic                     new_record,
   output logic [1:0]               state
);

   localparam int unsigned PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
   localparam int unsigned IDX_W = PTR_W + 1;
   localparam int unsigned ADD_W = SCORE_W + 1;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_PLAY   = 2'd1;
   localparam logic [1:0] ST_COMMIT = 2'd2;
   localparam logic [1:0] ST_HOLD   = 2'd3;

   logic [1:0]         state_nxt;
   logic [PTR_W-1:0]   ptr, ptr_nxt;
   logic [N_SRC-1:0]   ack_nxt;
   logic [SCORE_W-1:0] score_nxt, high_nxt;
   logic               rec_nxt;

   logic [PTS_W-1:0]   pts_arr [N_SRC];
   logic [N_SRC-1:0]   elig;
   logic [IDX_W-1:0]   idx;
   logic               gnt_vld;
   logic [PTR_W-1:0]   gnt_idx;
   logic [ADD_W-1:0]   sum;
   logic [SCORE_W-1:0] sum_sat;

   // State and all output registers; reset drops any in-flight ack
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         ptr        <= '0;
         evt_ack    <= '0;
         score      <= '0;
         high_score <= '0;
         new_record <= 1'b0;
      end else begin
         state      <= state_nxt;
         ptr        <= ptr_nxt;
         evt_ack    <= ack_nxt;
         score      <= score_nxt;
         high_score <= high_nxt;
         new_record <= rec_nxt;
      end
   end

   // Next-state: start wins in IDLE/HOLD, over wins in PLAY
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (game_start) state_nxt = ST_PLAY;
         ST_PLAY:   if (game_over)  state_nxt = ST_COMMIT;
         ST_COMMIT: state_nxt = ST_HOLD;
         ST_HOLD:   if (game_start) state_nxt = ST_PLAY;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // Round-robin pick among requesters not being acked this cycle
   always_comb begin
      elig    = evt_req & ~evt_ack;
      gnt_vld = 1'b0;
      gnt_idx = '0;
      idx     = '0;
      for (int k = 0; k < N_SRC; k++) begin
         pts_arr[k] = evt_pts[k*PTS_W +: PTS_W];
         idx = IDX_W'(ptr) + IDX_W'(k);
         if (idx >= IDX_W'(N_SRC)) idx = idx - IDX_W'(N_SRC);
         if (!gnt_vld && elig[idx[PTR_W-1:0]]) begin
            gnt_vld = 1'b1;
            gnt_idx = idx[PTR_W-1:0];
         end
      end
   end

   // Widened add so the sum never wraps before saturation
   always_comb begin
      sum     = ADD_W'(score) + ADD_W'(pts_arr[gnt_idx]);
      sum_sat = (sum > ADD_W'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : sum[SCORE_W-1:0];
   end

   // Next values for the registered outputs
   always_comb begin
      ack_nxt   = '0;
      ptr_nxt   = ptr;
      score_nxt = score;
      high_nxt  = high_score;
      rec_nxt   = new_record;
      case (state)
         ST_IDLE, ST_HOLD: begin
            if (game_start) begin
               score_nxt = '0;
               rec_nxt   = 1'b0;
            end
         end
         ST_PLAY: begin
            if (!game_over && gnt_vld) begin
               ack_nxt[gnt_idx] = 1'b1;
               score_nxt        = sum_sat;
               ptr_nxt          = (gnt_idx == PTR_W'(N_SRC-1)) ? '0 : gnt_idx + PTR_W'(1);
            end
         end
         ST_COMMIT: begin
            if (score > high_score) begin
               high_nxt = score;
               rec_nxt  = 1'b1;
            end else begin
               rec_nxt  = 1'b0;
            end
         end
         default: ;
      endcase
   end

endmodule
